// File: rtl/hdmi_rst_pkg.sv
// Shared definitions for the HDMI reset-release sequencer: FSM state
// encodings and default timing constants.
package hdmi_rst_pkg;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3
    } state_t;

    localparam int DEF_NUM_STAGES  = 3;
    localparam int DEF_LOCK_CYCLES = 1024;
    localparam int DEF_STAGE_GAP   = 16;
    localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/rst_cycle_cnt.sv
// Saturating up-counter with synchronous clear and a terminal-count compare.
module rst_cycle_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             i_srst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_tc_val,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_srst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_tc_val);

endmodule

// File: rtl/rst_release_seq.sv
// Sequenced reset-release controller: waits for a stable PLL lock, then
// releases the active-low stage resets one at a time, lowest bit first.
module rst_release_seq
    import hdmi_rst_pkg::*;
#(
    parameter int NUM_STAGES  = DEF_NUM_STAGES,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int STAGE_GAP   = DEF_STAGE_GAP,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  syn_reset,
    input  logic                  pll_locked,
    input  logic                  soft_rst_req,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  seq_done,
    output logic [2:0]            seq_state
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0]      LOCK_TC  = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0]      GAP_TC   = CNT_W'(STAGE_GAP - 1);
    localparam logic [NUM_STAGES-1:0] MASK_ONE = NUM_STAGES'(1);

    state_t                r_state, r_state_next;
    logic [NUM_STAGES-1:0] r_mask, r_mask_next;
    logic [IDX_W-1:0]      r_idx, r_idx_next;
    logic                  r_done, r_done_next;

    logic             w_lock_clr, w_lock_en, w_lock_tc;
    logic             w_gap_clr, w_gap_en, w_gap_tc;
    logic [CNT_W-1:0] w_lock_cnt, w_gap_cnt;
    logic             w_abort;

    rst_cycle_cnt #(.CNT_W(CNT_W)) u_lock_cnt (
        .clk      (clk),
        .i_srst   (syn_reset),
        .i_clr    (w_lock_clr),
        .i_en     (w_lock_en),
        .i_tc_val (LOCK_TC),
        .o_cnt    (w_lock_cnt),
        .o_tc     (w_lock_tc)
    );

    rst_cycle_cnt #(.CNT_W(CNT_W)) u_gap_cnt (
        .clk      (clk),
        .i_srst   (syn_reset),
        .i_clr    (w_gap_clr),
        .i_en     (w_gap_en),
        .i_tc_val (GAP_TC),
        .o_cnt    (w_gap_cnt),
        .o_tc     (w_gap_tc)
    );

    assign w_abort = !pll_locked || soft_rst_req;

    always_ff @(posedge clk) begin
        if (syn_reset) begin
            r_state <= ST_HOLD;
            r_mask  <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= r_state_next;
            r_mask  <= r_mask_next;
            r_idx   <= r_idx_next;
            r_done  <= r_done_next;
        end
    end

    always_comb begin
        r_state_next = r_state;
        r_mask_next  = r_mask;
        r_idx_next   = r_idx;
        r_done_next  = r_done;
        w_lock_clr   = 1'b0;
        w_lock_en    = 1'b0;
        w_gap_clr    = 1'b0;
        w_gap_en     = 1'b0;

        case (r_state)
            ST_HOLD: begin
                r_mask_next  = '0;
                r_idx_next   = '0;
                r_done_next  = 1'b0;
                w_lock_clr   = 1'b1;
                w_gap_clr    = 1'b1;
                r_state_next = ST_WAIT_LOCK;
            end

            ST_WAIT_LOCK: begin
                if (w_abort) begin
                    w_lock_clr = 1'b1;
                end else if (w_lock_tc) begin
                    r_state_next = ST_RELEASE;
                    r_idx_next   = '0;
                    r_mask_next  = MASK_ONE;
                    w_lock_clr   = 1'b1;
                    w_gap_clr    = 1'b1;
                end else begin
                    w_lock_en = 1'b1;
                end
            end

            ST_RELEASE: begin
                // Abort is checked first so it beats a release due this cycle.
                if (w_abort) begin
                    r_state_next = ST_HOLD;
                    r_mask_next  = '0;
                    r_idx_next   = '0;
                    r_done_next  = 1'b0;
                    w_lock_clr   = 1'b1;
                    w_gap_clr    = 1'b1;
                end else if (w_gap_tc) begin
                    w_gap_clr = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_state_next = ST_RUN;
                        r_done_next  = 1'b1;
                    end else begin
                        r_idx_next  = r_idx + IDX_W'(1);
                        // Sets only the lowest cleared bit, keeping release monotonic.
                        r_mask_next = r_mask | (r_mask + MASK_ONE);
                    end
                end else begin
                    w_gap_en = 1'b1;
                end
            end

            ST_RUN: begin
                if (w_abort) begin
                    r_state_next = ST_HOLD;
                    r_mask_next  = '0;
                    r_idx_next   = '0;
                    r_done_next  = 1'b0;
                    w_lock_clr   = 1'b1;
                    w_gap_clr    = 1'b1;
                end else begin
                    r_mask_next = '1;
                    r_done_next = 1'b1;
                end
            end

            default: begin
                r_state_next = ST_HOLD;
                r_mask_next  = '0;
                r_idx_next   = '0;
                r_done_next  = 1'b0;
                w_lock_clr   = 1'b1;
                w_gap_clr    = 1'b1;
            end
        endcase
    end

    assign stage_rst_n = r_mask;
    assign seq_done    = r_done;
    assign seq_state   = r_state;

endmodule

// File: tb/tb_rst_release_seq.sv
// Directed bench for rst_release_seq with NUM_STAGES=3, LOCK_CYCLES=8,
// STAGE_GAP=4; release latencies are counted in clock edges.
module tb_rst_release_seq;

    logic       clk;
    logic       syn_reset;
    logic       pll_locked;
    logic       soft_rst_req;
    logic [2:0] stage_rst_n;
    logic       seq_done;
    logic [2:0] seq_state;

    int tests_run    = 0;
    int tests_failed = 0;
    int illegal_seen = 0;

    rst_release_seq #(
        .NUM_STAGES  (3),
        .LOCK_CYCLES (8),
        .STAGE_GAP   (4),
        .CNT_W       (16)
    ) dut (
        .clk          (clk),
        .syn_reset    (syn_reset),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .stage_rst_n  (stage_rst_n),
        .seq_done     (seq_done),
        .seq_state    (seq_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Only the monotonic release patterns are ever legal.
    always @(negedge clk) begin
        if (!(stage_rst_n inside {3'b000, 3'b001, 3'b011, 3'b111}))
            illegal_seen = illegal_seen + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        tests_run = tests_run + 1;
        if (got != exp) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0d", tag, got);
        end
    endtask

    // Advance one clock edge; drive and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count edges until {seq_done, stage_rst_n} reaches target (bounded).
    task automatic wait_out(input string tag, input logic [3:0] target, input int exp);
        int n;
        n = 0;
        do begin
            step();
            n = n + 1;
        end while (({seq_done, stage_rst_n} != target) && (n < 200));
        check(tag, n, exp);
    endtask

    initial begin
        syn_reset    = 1'b1;
        pll_locked   = 1'b1;
        soft_rst_req = 1'b0;

        // 1: reset values, then nominal release timing
        repeat (5) step();
        check("rst_mask",  int'(stage_rst_n), 0);
        check("rst_done",  int'(seq_done),    0);
        check("rst_state", int'(seq_state),   0);
        syn_reset = 1'b0;
        wait_out("t1_bit0", 4'b0001, 9);
        check("t1_state_rel", int'(seq_state), 2);
        wait_out("t1_bit1", 4'b0011, 4);
        wait_out("t1_bit2", 4'b0111, 4);
        wait_out("t1_done", 4'b1111, 4);
        check("t1_state_run", int'(seq_state), 3);

        // 3: lock loss in RUN aborts, then full sequence repeats
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        check("t3_mask",  int'(stage_rst_n), 0);
        check("t3_done",  int'(seq_done),    0);
        check("t3_state", int'(seq_state),   0);
        wait_out("t3_bit0", 4'b0001, 9);
        wait_out("t3_done", 4'b1111, 12);

        // 2: lock glitch at lock_cnt = 5 restarts the lock count
        syn_reset = 1'b1;
        step();
        syn_reset = 1'b0;
        step();
        check("t2_state_wait", int'(seq_state), 1);
        repeat (5) step();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        check("t2_state_glitch", int'(seq_state), 1);
        wait_out("t2_bit0", 4'b0001, 8);

        // 4: soft reset in RELEASE suppresses the release due that edge
        repeat (3) step();
        soft_rst_req = 1'b1;
        step();
        soft_rst_req = 1'b0;
        check("t4_mask",  int'(stage_rst_n), 0);
        check("t4_state", int'(seq_state),   0);
        wait_out("t4_bit0", 4'b0001, 9);

        // 5: syn_reset together with soft reset mid-RELEASE
        repeat (2) step();
        syn_reset    = 1'b1;
        soft_rst_req = 1'b1;
        step();
        check("t5_mask",  int'(stage_rst_n), 0);
        check("t5_done",  int'(seq_done),    0);
        check("t5_state", int'(seq_state),   0);
        step();
        syn_reset = 1'b0;
        // soft request seen in HOLD must be ignored
        step();
        soft_rst_req = 1'b0;
        check("t5_hold_soft_ign", int'(seq_state), 1);
        wait_out("t5_bit0", 4'b0001, 8);
        wait_out("t5_done", 4'b1111, 12);

        // 7: soft reset in WAIT_LOCK clears lock count, stays in WAIT_LOCK
        syn_reset = 1'b1;
        step();
        syn_reset = 1'b0;
        step();
        repeat (4) step();
        soft_rst_req = 1'b1;
        step();
        soft_rst_req = 1'b0;
        check("t7_state_wait", int'(seq_state), 1);
        wait_out("t7_bit0", 4'b0001, 8);

        // 6: monotonic release pattern held over the whole run
        check("t6_legal_mask", illegal_seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
